// File: rtl/ddr3_tg_pkg.sv
// Shared types and constants for the DDR3 traffic generator.
// Optional LFSR pattern build: define DDR3_LFSR_PATTERN_EN.
package ddr3_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT_RD,
    ST_DONE
  } tg_state_t;

  localparam logic [2:0]  CMD_WR    = 3'b000;
  localparam logic [2:0]  CMD_RD    = 3'b001;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // One right-shifting Galois step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ddr3_tg_pattern.sv
// Pattern word generator; word_c is the word that becomes current after this edge.
// DDR3_LFSR_PATTERN_EN selects per-lane LFSRs instead of the index-based ramp.
module ddr3_tg_pattern #(
  parameter int unsigned DATA_W = 128,
  parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
`ifdef DDR3_LFSR_PATTERN_EN
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
`else
  input  logic [15:0]       idx,
`endif
  output logic [DATA_W-1:0] word_c
);

  localparam int unsigned LANES = DATA_W / 32;

`ifdef DDR3_LFSR_PATTERN_EN
  import ddr3_tg_pkg::*;

  logic [31:0] lane_q [LANES];
  logic [31:0] lane_d [LANES];

  // Lookahead: reload on pass start, advance once per word.
  always_comb begin
    word_c = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_d[k] = lane_q[k];
      if (load) begin
        lane_d[k] = SEED ^ 32'(k);
      end else if (step) begin
        lane_d[k] = lfsr_step(lane_q[k]);
      end
      word_c[32*k +: 32] = lane_d[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (rst) begin
        lane_q[k] <= '0;
      end else begin
        lane_q[k] <= lane_d[k];
      end
    end
  end
`else
  always_comb begin
    word_c = '0;
    for (int k = 0; k < LANES; k++) begin
      word_c[32*k +: 32] = SEED + 32'(idx) + 32'(k);
    end
  end
`endif

endmodule

// File: rtl/ddr3_traffic_gen.sv
// Writes a pattern to NUM_WORDS DDR3 locations, reads them back and counts mismatches.
// Build option: DDR3_LFSR_PATTERN_EN switches the pattern to per-lane LFSRs.
module ddr3_traffic_gen
  import ddr3_tg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned ADDR_STEP = 8,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              init_calib_complete,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_wdf_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [15:0]       first_err_idx
);

  localparam int unsigned      CNT_W   = $clog2(NUM_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] END_CNT = CNT_W'(NUM_WORDS);

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] i);
    return ADDR_W'(32'(i) * 32'(ADDR_STEP));
  endfunction

  tg_state_t         state_q, state_d;
  logic [CNT_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, chk_idx_q, chk_idx_d;
  logic              cmd_ok_q, cmd_ok_d, dat_ok_q, dat_ok_d, err_seen_q, err_seen_d;
  logic              cmp_vld_q, cmp_vld_d, cmp_bad_q, cmp_bad_d;
  logic [15:0]       cmp_idx_q, cmp_idx_d;
  logic [DATA_W-1:0] exp_word_q, wr_word_c, chk_word_c;

  logic              app_en_d, app_wdf_wren_d, busy_d, done_d, pass_d;
  logic [2:0]        app_cmd_d;
  logic [ADDR_W-1:0] app_addr_d;
  logic [DATA_W-1:0] app_wdf_data_d;
  logic [15:0]       err_cnt_d, first_err_idx_d;

  logic cmd_acc_c, dat_acc_c, pass_start_c, word_adv_c, chk_hit_c, abort_c;

  assign cmd_acc_c    = app_en && app_rdy;
  assign dat_acc_c    = app_wdf_wren && app_wdf_rdy;
  assign pass_start_c = (state_q == ST_IDLE || state_q == ST_DONE) && start && init_calib_complete;
  assign word_adv_c   = (state_q == ST_WRITE) && (cmd_ok_q || cmd_acc_c) && (dat_ok_q || dat_acc_c);
  assign chk_hit_c    = (state_q == ST_READ || state_q == ST_WAIT_RD) && app_rd_data_valid
                        && (chk_idx_q != END_CNT);
  assign abort_c      = !init_calib_complete
                        && (state_q == ST_WRITE || state_q == ST_READ || state_q == ST_WAIT_RD);

`ifdef DDR3_LFSR_PATTERN_EN
  ddr3_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_pat (
    .clk(clk_in), .rst(rst), .load(pass_start_c), .step(word_adv_c), .word_c(wr_word_c)
  );
  ddr3_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_chk_pat (
    .clk(clk_in), .rst(rst), .load(pass_start_c), .step(chk_hit_c), .word_c(chk_word_c)
  );
`else
  logic [15:0] wr_pat_idx, chk_pat_idx;
  // Write data is only loaded at pass start (word 0) or on advancing to wr_idx+1.
  assign wr_pat_idx  = (state_q == ST_WRITE) ? 16'(wr_idx_q + CNT_W'(1)) : 16'd0;
  assign chk_pat_idx = pass_start_c ? 16'd0
                     : (chk_hit_c ? 16'(chk_idx_q + CNT_W'(1)) : 16'(chk_idx_q));
  ddr3_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_pat (
    .idx(wr_pat_idx), .word_c(wr_word_c)
  );
  ddr3_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_chk_pat (
    .idx(chk_pat_idx), .word_c(chk_word_c)
  );
`endif

  always_comb begin
    state_d         = state_q;
    app_en_d        = app_en;
    app_cmd_d       = app_cmd;
    app_addr_d      = app_addr;
    app_wdf_wren_d  = app_wdf_wren;
    app_wdf_data_d  = app_wdf_data;
    wr_idx_d        = wr_idx_q;
    rd_idx_d        = rd_idx_q;
    chk_idx_d       = chk_idx_q;
    cmd_ok_d        = cmd_ok_q;
    dat_ok_d        = dat_ok_q;
    busy_d          = busy;
    done_d          = done;
    pass_d          = pass;
    err_cnt_d       = err_cnt;
    first_err_idx_d = first_err_idx;
    err_seen_d      = err_seen_q;
    cmp_vld_d       = 1'b0;
    cmp_bad_d       = 1'b0;
    cmp_idx_d       = cmp_idx_q;

    // Second stage of the read-data check: apply last cycle's compare.
    if (cmp_vld_q && cmp_bad_q) begin
      if (err_cnt != 16'hFFFF) err_cnt_d = err_cnt + 16'd1;
      if (!err_seen_q) begin
        first_err_idx_d = cmp_idx_q;
        err_seen_d      = 1'b1;
      end
    end

    if (chk_hit_c) begin
      cmp_vld_d = 1'b1;
      cmp_bad_d = (app_rd_data != exp_word_q);
      cmp_idx_d = 16'(chk_idx_q);
      chk_idx_d = chk_idx_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (pass_start_c) begin
          state_d         = ST_WRITE;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          err_seen_d      = 1'b0;
          wr_idx_d        = '0;
          rd_idx_d        = '0;
          chk_idx_d       = '0;
          cmd_ok_d        = 1'b0;
          dat_ok_d        = 1'b0;
          app_en_d        = 1'b1;
          app_cmd_d       = CMD_WR;
          app_addr_d      = '0;
          app_wdf_wren_d  = 1'b1;
          app_wdf_data_d  = wr_word_c;
        end
      end
      ST_WRITE: begin
        if (cmd_acc_c) app_en_d = 1'b0;
        if (dat_acc_c) app_wdf_wren_d = 1'b0;
        if (word_adv_c) begin
          cmd_ok_d = 1'b0;
          dat_ok_d = 1'b0;
          wr_idx_d = wr_idx_q + CNT_W'(1);
          app_en_d = 1'b1;
          if (wr_idx_q == LAST) begin
            state_d    = ST_READ;
            app_cmd_d  = CMD_RD;
            app_addr_d = '0;
          end else begin
            app_wdf_wren_d = 1'b1;
            app_addr_d     = word_addr(wr_idx_q + CNT_W'(1));
            app_wdf_data_d = wr_word_c;
          end
        end else begin
          cmd_ok_d = cmd_ok_q || cmd_acc_c;
          dat_ok_d = dat_ok_q || dat_acc_c;
        end
      end
      ST_READ: begin
        if (cmd_acc_c) begin
          rd_idx_d = rd_idx_q + CNT_W'(1);
          if (rd_idx_q == LAST) begin
            app_en_d = 1'b0;
            state_d  = ST_WAIT_RD;
          end else begin
            app_addr_d = word_addr(rd_idx_q + CNT_W'(1));
          end
        end
      end
      ST_WAIT_RD: begin
        if (chk_idx_q == END_CNT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 16'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Calibration loss drops the pass but keeps the counters for inspection.
    if (abort_c) begin
      state_d        = ST_IDLE;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      app_en_d       = 1'b0;
      app_wdf_wren_d = 1'b0;
      cmd_ok_d       = 1'b0;
      dat_ok_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      app_en        <= 1'b0;
      app_cmd       <= '0;
      app_addr      <= '0;
      app_wdf_wren  <= 1'b0;
      app_wdf_end   <= 1'b0;
      app_wdf_data  <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      chk_idx_q     <= '0;
      cmd_ok_q      <= 1'b0;
      dat_ok_q      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      err_seen_q    <= 1'b0;
      cmp_vld_q     <= 1'b0;
      cmp_bad_q     <= 1'b0;
      cmp_idx_q     <= '0;
      exp_word_q    <= '0;
    end else begin
      state_q       <= state_d;
      app_en        <= app_en_d;
      app_cmd       <= app_cmd_d;
      app_addr      <= app_addr_d;
      app_wdf_wren  <= app_wdf_wren_d;
      app_wdf_end   <= app_wdf_wren_d;
      app_wdf_data  <= app_wdf_data_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      chk_idx_q     <= chk_idx_d;
      cmd_ok_q      <= cmd_ok_d;
      dat_ok_q      <= dat_ok_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      err_cnt       <= err_cnt_d;
      first_err_idx <= first_err_idx_d;
      err_seen_q    <= err_seen_d;
      cmp_vld_q     <= cmp_vld_d;
      cmp_bad_q     <= cmp_bad_d;
      cmp_idx_q     <= cmp_idx_d;
      exp_word_q    <= chk_word_c;
    end
  end

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Scoreboard bench for ddr3_traffic_gen: memory model with random ready/latency,
// expected transactions queued at stimulus time and popped by bus/status monitors.
module tb_ddr3_traffic_gen;

  localparam int          NW   = 256;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic         clk_in = 1'b0;
  logic         rst, start, init_calib_complete;
  logic         app_rdy, app_en, app_wdf_rdy, app_wdf_wren, app_wdf_end;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic [127:0] app_wdf_data, app_rd_data;
  logic         app_rd_data_valid, busy, done, pass;
  logic [15:0]  err_cnt, first_err_idx;

  ddr3_traffic_gen #(
    .ADDR_W(28), .DATA_W(128), .NUM_WORDS(NW), .ADDR_STEP(8), .SEED(SEED)
  ) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int addr; int rel; } rd_t;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, last_rel = 0, status_seen = 0, rd_valid_cnt = 0, rd_cmd_cnt = 0;
  int rdy_rand = 0, wdf_rand = 0, lat_max = 0, corrupt_a = -1, corrupt_b = -1;
  logic done_prev = 1'b0;

  logic [27:0]  exp_waddr[$], exp_raddr[$];
  logic [127:0] exp_wdata[$];
  logic [34:0]  exp_status[$];
  int           pend_wa[$];
  logic [127:0] pend_wd[$];
  rd_t          rq[$];
  logic [127:0] mem [int];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 128'd0;
  endfunction

  function automatic logic [127:0] exp_word(input int i);
    logic [127:0] w;
`ifdef DDR3_LFSR_PATTERN_EN
    logic [31:0] s;
`endif
    w = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef DDR3_LFSR_PATTERN_EN
      s = SEED ^ 32'(k);
      for (int n = 0; n < i; n++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      w[32*k +: 32] = s;
`else
      w[32*k +: 32] = SEED + 32'(i) + 32'(k);
`endif
    end
    return w;
  endfunction

  // Ready generation.
  initial begin
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      app_rdy     = (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      app_wdf_rdy = (wdf_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Read-data return, in order, with the latency chosen at command time.
  initial begin
    rd_t r;
    logic [127:0] d;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk_in); #1;
      cyc++;
      if (rq.size() > 0 && rq[0].rel <= cyc) begin
        r = rq.pop_front();
        d = mem_rd(r.addr);
        if (r.addr / 8 == corrupt_a || r.addr / 8 == corrupt_b) d[0] = ~d[0];
        app_rd_data_valid = 1'b1;
        app_rd_data = d;
        rd_valid_cnt++;
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Bus monitor: pops expected commands/data on every handshake.
  initial begin
    logic [27:0] ea;
    logic [127:0] ed;
    int rel;
    forever begin
      @(negedge clk_in);
      if (app_en && app_rdy && app_cmd == 3'b000) begin
        if (exp_waddr.size() == 0) chk("wr_cmd_unexpected", app_en, 0);
        else begin
          ea = exp_waddr.pop_front();
          chk("wr_addr", app_addr, ea);
        end
        pend_wa.push_back(int'(app_addr));
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (exp_wdata.size() == 0) chk("wr_data_unexpected", app_wdf_wren, 0);
        else begin
          ed = exp_wdata.pop_front();
          chk("wr_data_end", {app_wdf_end, app_wdf_data}, {1'b1, ed});
        end
        pend_wd.push_back(app_wdf_data);
      end
      while (pend_wa.size() > 0 && pend_wd.size() > 0) mem[pend_wa.pop_front()] = pend_wd.pop_front();
      if (app_en && app_cmd > 3'b001) chk("cmd_code", app_cmd, 1);
      if (app_en && app_rdy && app_cmd == 3'b001) begin
        if (exp_raddr.size() == 0) chk("rd_cmd_unexpected", app_en, 0);
        else begin
          ea = exp_raddr.pop_front();
          chk("rd_addr", app_addr, ea);
        end
        rd_cmd_cnt++;
        rel = cyc + 1 + int'($urandom_range(0, lat_max));
        if (rel <= last_rel) rel = last_rel + 1;
        last_rel = rel;
        rq.push_back('{addr: int'(app_addr), rel: rel});
      end
    end
  end

  // Status monitor: checks the end-of-pass report when done rises.
  initial begin
    logic [34:0] es;
    forever begin
      @(negedge clk_in);
      if (done && !done_prev) begin
        if (exp_status.size() == 0) chk("done_unexpected", done, 0);
        else begin
          es = exp_status.pop_front();
          chk("status", {busy, done, pass, err_cnt, first_err_idx}, es);
          chk("rd_valid_before_done", rd_valid_cnt, NW);
        end
        status_seen++;
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(posedge clk_in); #1;
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
  endtask

  task automatic load_expect();
    for (int i = 0; i < NW; i++) begin
      exp_waddr.push_back(28'(i * 8));
      exp_wdata.push_back(exp_word(i));
      exp_raddr.push_back(28'(i * 8));
    end
    rd_valid_cnt = 0;
    rd_cmd_cnt = 0;
  endtask

  task automatic run_pass(input int ca, input int cb, input logic [15:0] e_err,
                          input logic [15:0] e_first, input logic e_pass, input int mid_start);
    int base, t;
    corrupt_a = ca;
    corrupt_b = cb;
    load_expect();
    exp_status.push_back({1'b0, 1'b1, e_pass, e_err, e_first});
    base = status_seen;
    pulse_start();
    t = 0;
    while (status_seen == base && t < 20000) begin
      @(posedge clk_in); #1;
      t++;
      start = (mid_start != 0 && t == 50);
    end
    start = 1'b0;
    chk("pass_done_seen", status_seen - base, 1);
    chk("queues_drained", {exp_waddr.size(), exp_wdata.size(), exp_raddr.size()}, 0);
  endtask

  initial begin
    int t;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    init_calib_complete = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst = 1'b0;
    @(negedge clk_in);
    chk("reset_outputs", {app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
                          busy, done, pass, err_cnt, first_err_idx}, 0);
    chk("reset_wdata", app_wdf_data, 0);

    // Start without calibration is ignored.
    pulse_start();
    repeat (5) @(negedge clk_in);
    chk("calib_low_ignored", {busy, app_en, app_wdf_wren}, 0);

    // Clean pass, always-ready controller, minimal latency.
    init_calib_complete = 1'b1;
    run_pass(-1, -1, 16'd0, 16'd0, 1'b1, 0);
    repeat (10) @(negedge clk_in);
    chk("done_held", {busy, done, pass}, 3'b011);
    chk("last_addr_written", mem.exists(2040), 1);
`ifdef DDR3_LFSR_PATTERN_EN
    chk("lfsr_w0_l0", mem_rd(0) & 128'hFFFF_FFFF, 128'hA5A5_0000);
    chk("lfsr_w1_l0", mem_rd(8) & 128'hFFFF_FFFF, 128'h52D2_8000);
`else
    chk("word5_data", mem_rd(40), 128'hA5A5_0008_A5A5_0007_A5A5_0006_A5A5_0005);
`endif

    // Random independent ready, 0-20 cycle read latency, stray start mid-pass.
    rdy_rand = 1;
    wdf_rand = 1;
    lat_max = 20;
    run_pass(-1, -1, 16'd0, 16'd0, 1'b1, 1);

    // Corrupted readback of words 17 and 200.
    run_pass(17, 200, 16'd2, 16'd17, 1'b0, 0);
    corrupt_a = -1;
    corrupt_b = -1;

    // Calibration loss during READ.
    load_expect();
    pulse_start();
    t = 0;
    while (rd_cmd_cnt < 100 && t < 20000) begin
      @(negedge clk_in);
      t++;
    end
    chk("abort_reached_read", rd_cmd_cnt >= 100, 1);
    @(posedge clk_in); #1;
    init_calib_complete = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("abort_idle", {busy, done, app_en, app_wdf_wren}, 0);
    t = 0;
    while (rq.size() > 0 && t < 5000) begin
      @(negedge clk_in);
      t++;
    end
    chk("abort_rd_drained", rq.size(), 0);
    chk("abort_no_done", {done, busy}, 0);
    exp_raddr.delete();
    @(posedge clk_in); #1;
    init_calib_complete = 1'b1;
    run_pass(-1, -1, 16'd0, 16'd0, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
